// File: rtl/sext_rr_sched.sv
// -----------------------------------------------------------------------------
// sext_rr_sched
//
// Round-robin scheduler that lets NUM_REQ requesters share one registered
// sign-extension unit. Each cycle at most one requester is granted. Its narrow
// two's-complement immediate is sign-extended into a single output register
// and tagged with the requester index. The output side uses valid/ready
// handshaking. Back-to-back operation sustains one result per cycle.
//
// Optional feature (macro SEXT_SCHED_STATS_EN):
//   Adds a 16-bit grant_count output that counts accepted requests and
//   saturates at 0xFFFF.
//
// Ports:
//   clk          system clock, all state updates on posedge
//   reset        synchronous, active-high reset
//   req          per-requester request level, held until granted
//   req_data     packed immediates, requester i at [i*IN_W +: IN_W]
//   gnt          one-hot grant, combinational, asserted in the accept cycle
//   out_valid    output register holds a result
//   out_ready    consumer takes the result this cycle
//   out_data     sign-extended result
//   out_id       index of the requester that produced out_data
//   grant_count  (SEXT_SCHED_STATS_EN only) saturating accept counter
// -----------------------------------------------------------------------------
module sext_rr_sched #(
  parameter int NUM_REQ = 4,
  parameter int IN_W    = 2,
  parameter int OUT_W   = 8,
  parameter int ID_W    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*IN_W-1:0] req_data,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic [ID_W-1:0]         out_id
`ifdef SEXT_SCHED_STATS_EN
  ,
  output logic [15:0]             grant_count
`endif
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [OUT_W-1:0]   out_data_reg;
  logic [ID_W-1:0]    out_id_reg;
  logic               load;

  // ---------------------------------------------------------------------------
  // Grant selection
  // The request vector is rotated so that bit 0 corresponds to rr_ptr. The
  // lowest set bit of the rotated vector is the winner's offset from rr_ptr.
  // ---------------------------------------------------------------------------
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [PTR_W-1:0]     first_off;
  logic [PTR_W:0]       sel_sum;
  logic [PTR_W-1:0]     sel;
  logic                 accept;

  assign req_dbl = {req, req} >> rr_ptr_reg;
  assign req_rot = req_dbl[NUM_REQ-1:0];

  always_comb begin
    first_off = '0;
    // Scan from the top so that the lowest set offset wins.
    for (int p = NUM_REQ - 1; p >= 0; p--) begin
      if (req_rot[p]) begin
        first_off = PTR_W'(p);
      end
    end
  end

  // Map the offset back to an absolute index, modulo NUM_REQ.
  assign sel_sum = {1'b0, rr_ptr_reg} + {1'b0, first_off};
  assign sel     = (sel_sum >= (PTR_W+1)'(NUM_REQ))
                   ? PTR_W'(sel_sum - (PTR_W+1)'(NUM_REQ))
                   : sel_sum[PTR_W-1:0];

  // A grant raised during reset would be discarded anyway, so suppress it.
  assign accept = (|req) && ((state_reg == EMPTY) || out_ready) && !reset;

  logic [IN_W-1:0] imm [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign gnt[gi] = accept && (sel == PTR_W'(gi));
    assign imm[gi] = req_data[gi*IN_W +: IN_W];
  end

  logic [IN_W-1:0]  sel_imm;
  logic [OUT_W-1:0] sel_ext;

  assign sel_imm = imm[sel];
  assign sel_ext = {{(OUT_W-IN_W){sel_imm[IN_W-1]}}, sel_imm};

  // Next round-robin pointer: one past the winner, wrapping to 0.
  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (accept) begin
      if (sel == PTR_W'(NUM_REQ - 1)) begin
        rr_ptr_next = '0;
      end else begin
        rr_ptr_next = sel + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output register state machine
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= EMPTY;
      rr_ptr_reg <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = FULL;
          load       = 1'b1;
        end
      end
      FULL: begin
        out_valid = 1'b1;
        // accept already implies out_ready here, so a drain and a reload
        // coincide in one cycle without losing or repeating a result.
        if (accept) begin
          load = 1'b1;
        end else if (out_ready) begin
          state_next = EMPTY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_reg <= '0;
      out_id_reg   <= '0;
    end else if (load) begin
      out_data_reg <= sel_ext;
      out_id_reg   <= ID_W'(sel);
    end
  end

  assign out_data = out_data_reg;
  assign out_id   = out_id_reg;

`ifdef SEXT_SCHED_STATS_EN
  logic [15:0] grant_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_count_reg <= '0;
    end else if (accept && (grant_count_reg != 16'hFFFF)) begin
      grant_count_reg <= grant_count_reg + 16'd1;
    end
  end

  assign grant_count = grant_count_reg;
`endif

endmodule

// File: tb/tb_sext_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_sext_rr_sched
//
// Self-checking bench for sext_rr_sched. A behavioural model (pointer, a
// single-entry output slot and arithmetic sign extension) predicts grants
// and outputs. Inputs are driven on the falling edge. gnt is checked 1 ns
// later, and registered outputs are checked on the next falling edge.
// -----------------------------------------------------------------------------
module tb_sext_rr_sched;

  localparam int N     = 4;
  localparam int IN_W  = 2;
  localparam int OUT_W = 8;
  localparam int ID_W  = 2;

  logic                 clk;
  logic                 reset;
  logic [N-1:0]         req;
  logic [N*IN_W-1:0]    req_data;
  logic [N-1:0]         gnt;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic [ID_W-1:0]      out_id;
`ifdef SEXT_SCHED_STATS_EN
  logic [15:0]          grant_count;
`endif

  sext_rr_sched #(
    .NUM_REQ(N), .IN_W(IN_W), .OUT_W(OUT_W), .ID_W(ID_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .req_data(req_data),
    .gnt(gnt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_id(out_id)
`ifdef SEXT_SCHED_STATS_EN
    ,
    .grant_count(grant_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int           m_ptr   = 0;
  bit           m_valid = 1'b0;
  int           m_data  = 0;
  int           m_id    = 0;
  int           m_count = 0;
  logic [N-1:0] exp_gnt;

  // Two's-complement value of d, reduced modulo 2^OUT_W.
  function automatic int ext_model(input int d);
    if (d >= (1 << (IN_W - 1))) return (d - (1 << IN_W)) & ((1 << OUT_W) - 1);
    return d;
  endfunction

  // Winner index, or -1 when nothing is accepted this cycle.
  function automatic int model_winner();
    if (reset || req == '0 || (m_valid && !out_ready)) return -1;
    for (int off = 0; off < N; off++) begin
      if (req[(m_ptr + off) % N]) return (m_ptr + off) % N;
    end
    return -1;
  endfunction

  task automatic drive(input logic [N-1:0] r, input logic [N*IN_W-1:0] d,
                       input logic rdy, input logic rst);
    int w;
    req = r; req_data = d; out_ready = rdy; reset = rst;
    #1;
    w = model_winner();
    exp_gnt = (w < 0) ? '0 : N'(1 << w);
  endtask

  // Advance one clock and apply the model's rules for that edge.
  task automatic tick();
    int w;
    @(posedge clk);
    w = model_winner();
    if (reset) begin
      m_valid = 1'b0; m_data = 0; m_id = 0; m_ptr = 0; m_count = 0;
    end else if (w >= 0) begin
      m_valid = 1'b1;
      m_data  = ext_model(int'((req_data >> (w * IN_W)) & ((1 << IN_W) - 1)));
      m_id    = w;
      m_ptr   = (w + 1) % N;
      if (m_count < 16'hFFFF) m_count++;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive('0, '0, 1'b0, 1'b1);
    tick();
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", out_data); end
    checks++; if (out_id !== 2'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", out_id); end
    drive(4'b1111, '0, 1'b1, 1'b1);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    tick();
    $display("test_reset done");
  endtask

  task automatic test_single();
    drive(4'b0001, 8'b00_00_00_10, 1'b1, 1'b0);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hFE || out_id !== 2'd0) begin
      failures++; $display("FAIL single_out got=%b/%h/%0d exp=1/fe/0", out_valid, out_data, out_id); end
    drive('0, '0, 1'b1, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%b exp=0", out_valid); end
    $display("test_single done");
  endtask

  task automatic test_rotation();
    int          ids [5]   = '{0, 1, 2, 3, 0};
    logic [7:0]  datas [5] = '{8'h00, 8'hFE, 8'h01, 8'hFF, 8'h00};
    drive('0, '0, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(4'b1111, 8'b11_01_10_00, 1'b1, 1'b0);
      checks++; if (gnt !== 4'(1 << ids[i])) begin
        failures++; $display("FAIL rot_gnt[%0d] got=%b exp=%b", i, gnt, 4'(1 << ids[i])); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== datas[i] || out_id !== 2'(ids[i])) begin
        failures++; $display("FAIL rot_out[%0d] got=%b/%h/%0d exp=1/%h/%0d", i, out_valid, out_data, out_id, datas[i], ids[i]); end
      $display("rotation grant=%0d data=%h", out_id, out_data);
    end
    drive('0, '0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_backpressure();
    drive('0, '0, 1'b0, 1'b1);
    tick();
    drive(4'b1000, 8'b11_00_00_00, 1'b1, 1'b0);
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL bp_first_gnt got=%b exp=1000", gnt); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF || out_id !== 2'd3) begin
      failures++; $display("FAIL bp_load got=%b/%h/%0d exp=1/ff/3", out_valid, out_data, out_id); end
    for (int i = 0; i < 3; i++) begin
      drive(4'b0010, 8'(8'b00_00_01_00 ^ (i << 6)), 1'b0, 1'b0);
      checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL bp_stall_gnt[%0d] got=%b exp=0000", i, gnt); end
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== 8'hFF || out_id !== 2'd3) begin
        failures++; $display("FAIL bp_hold[%0d] got=%b/%h/%0d exp=1/ff/3", i, out_valid, out_data, out_id); end
    end
    drive(4'b0010, 8'b00_00_01_00, 1'b1, 1'b0);
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL bp_release_gnt got=%b exp=0010", gnt); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 8'h01 || out_id !== 2'd1) begin
      failures++; $display("FAIL bp_reload got=%b/%h/%0d exp=1/01/1", out_valid, out_data, out_id); end
    drive('0, '0, 1'b1, 1'b0);
    tick();
    $display("test_backpressure done");
  endtask

  task automatic test_wrap();
    drive(4'b1000, 8'b01_00_00_00, 1'b1, 1'b0);
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL wrap_g3 got=%b exp=1000", gnt); end
    tick();
    drive(4'b1001, 8'b01_00_00_11, 1'b1, 1'b0);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wrap_g0 got=%b exp=0001", gnt); end
    tick();
    checks++; if (out_data !== 8'hFF || out_id !== 2'd0) begin
      failures++; $display("FAIL wrap_out got=%h/%0d exp=ff/0", out_data, out_id); end
    drive(4'b1000, 8'b01_00_00_00, 1'b1, 1'b0);
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL wrap_g3b got=%b exp=1000", gnt); end
    tick();
    drive('0, '0, 1'b1, 1'b0);
    tick();
    $display("test_wrap done");
  endtask

  task automatic test_reset_mid();
    drive(4'b1111, 8'b11_01_10_00, 1'b1, 1'b0);
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    drive(4'b1111, 8'b11_01_10_00, 1'b1, 1'b1);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL mid_rst_gnt got=%b exp=0000", gnt); end
    tick();
    checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      failures++; $display("FAIL mid_rst_out got=%b/%h exp=0/00", out_valid, out_data); end
    drive(4'b1111, 8'b11_01_10_00, 1'b1, 1'b0);
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL mid_after_gnt got=%b exp=0001", gnt); end
    tick();
    drive('0, '0, 1'b1, 1'b0);
    tick();
    $display("test_reset_mid done");
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(N'($urandom), (N*IN_W)'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 99) == 0));
      checks++; if (gnt !== exp_gnt) begin
        failures++; $display("FAIL rand_gnt[%0d] got=%b exp=%b", i, gnt, exp_gnt); end
      tick();
      checks++; if (out_valid !== m_valid) begin
        failures++; $display("FAIL rand_valid[%0d] got=%b exp=%b", i, out_valid, m_valid); end
      else if (m_valid && (out_data !== 8'(m_data) || out_id !== 2'(m_id))) begin
        failures++; $display("FAIL rand_out[%0d] got=%h/%0d exp=%h/%0d", i, out_data, out_id, 8'(m_data), m_id); end
      if (exp_gnt != '0) $display("txn %0d id=%0d data=%h", i, m_id, 8'(m_data));
    end
    drive('0, '0, 1'b1, 1'b0);
    tick();
  endtask

`ifdef SEXT_SCHED_STATS_EN
  task automatic test_stats();
    drive('0, '0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(4'b0100, '0, 1'b1, 1'b0);
      tick();
    end
    checks++; if (grant_count !== 16'd5 || m_count != 5) begin
      failures++; $display("FAIL stats_five got=%0d exp=5", grant_count); end
    for (int i = 0; i < 65535; i++) begin
      drive(4'b0001, '0, 1'b1, 1'b0);
      tick();
    end
    checks++; if (grant_count !== 16'hFFFF) begin
      failures++; $display("FAIL stats_sat got=%h exp=ffff", grant_count); end
    for (int i = 0; i < 3; i++) begin
      drive(4'b0011, '0, 1'b1, 1'b0);
      tick();
    end
    checks++; if (grant_count !== 16'(m_count) || grant_count !== 16'hFFFF) begin
      failures++; $display("FAIL stats_hold got=%h exp=ffff", grant_count); end
    $display("test_stats done");
  endtask
`endif

  initial begin
    req = '0; req_data = '0; out_ready = 1'b0; reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_random();
`ifdef SEXT_SCHED_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
